mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_ctrl_pkg.sv | 17 +
 rtl/mul_resp_fifo.sv | 55 +++++
 rtl/mul_issue_ctrl.sv | 109 ++++++++++
 tb/tb_mul_issue_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: RV32M multiply funct3 codes, operand sign encodings and response entry type.
package mul_ctrl_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } funct3_e;
  localparam logic [1:0] SIGN_UU = 2'b00;
  localparam logic [1:0] SIGN_SU = 2'b10;
  localparam logic [1:0] SIGN_SS = 2'b11;
  localparam int RD_MAX_W = 8;
  typedef struct packed {
    logic [RD_MAX_W-1:0] rd;
    logic [31:0]         data;
  } resp_entry_t;
endpackage

// File: rtl/mul_resp_fifo.sv
// mul_resp_fifo: first-word-fall-through FIFO; a push into an empty FIFO is visible on the
// output in the same cycle, and a simultaneous pop consumes it without touching storage.
module mul_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty, full, wr, rd;
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == CW'(DEPTH);
    wr      = push_i && !(empty && pop_i) && !clr_i;
    rd      = pop_i && !empty;
    valid_o = !empty || push_i;
    dout_o  = !empty ? mem_q[rptr_q] : (push_i ? din_i : '0);
    wptr_d  = wr ? ((wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1)) : wptr_q;
    rptr_d  = rd ? ((rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1)) : rptr_q;
    cnt_d   = cnt_q + CW'(wr) - CW'(rd);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (wr) mem_q[wptr_q] <= din_i;
    end
  end
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full))
    else $error("push into full response FIFO");
`endif
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: credit-based issue control for a fixed-latency RV32M multiplier.
// Define MUL_PERF_EN to build the issue and blocked-cycle performance counters.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int LAT  = 3,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [RD_W-1:0] req_rd_i,
  input  logic            flush_i,
  output logic            mul_start_o,
  output logic [1:0]      mul_sign_o,
  output logic            mul_higher_o,
  input  logic [31:0]     res_data_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [RD_W-1:0] resp_rd_o,
  output logic [31:0]     resp_data_o,
  output logic [31:0]     perf_issue_o,
  output logic [31:0]     perf_block_o
);
  localparam int CW = $clog2(LAT + 2);
  if (RD_W > RD_MAX_W) begin : g_rd_w_check
    $error("RD_W exceeds RD_MAX_W of the response entry");
  end
  logic [LAT-1:0] vld_q, vld_d;
  logic [RD_W-1:0] tag_q [LAT];
  logic [RD_W-1:0] tag_d [LAT];
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue, push, pop, fifo_valid;
  resp_entry_t push_ent, pop_ent;
  // ready is gated by rst_n so nothing issues while the block is held in reset
  always_comb begin
    req_ready_o  = rst_n && !flush_i && (cnt_q < CW'(LAT + 1));
    issue        = req_valid_i && req_ready_o;
    mul_start_o  = issue;
    mul_sign_o   = !issue ? SIGN_UU :
                   (req_funct3_i == MULH)   ? SIGN_SS :
                   (req_funct3_i == MULHSU) ? SIGN_SU : SIGN_UU;
    mul_higher_o = issue && (req_funct3_i != MUL);
    vld_d        = flush_i ? '0 : ((vld_q << 1) | LAT'(issue));
    tag_d[0]     = req_rd_i;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
    push          = vld_q[LAT-1] && !flush_i;
    push_ent.rd   = RD_MAX_W'(tag_q[LAT-1]);
    push_ent.data = res_data_i;
    resp_valid_o  = fifo_valid;
    pop           = fifo_valid && resp_ready_i && !flush_i;
    resp_rd_o     = pop_ent.rd[RD_W-1:0];
    resp_data_o   = pop_ent.data;
    cnt_d         = flush_i ? '0 : cnt_q + CW'(issue) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end
  mul_resp_fifo #(
    .DEPTH(LAT + 1),
    .W    ($bits(resp_entry_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_i),
    .push_i (push),
    .din_i  (push_ent),
    .pop_i  (pop),
    .valid_o(fifo_valid),
    .dout_o (pop_ent)
  );
`ifdef MUL_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_block_q, perf_block_d;
  always_comb begin
    perf_issue_d = perf_issue_q + 32'(issue);
    perf_block_d = perf_block_q + 32'(req_valid_i && !req_ready_o);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_block_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_block_q <= perf_block_d;
    end
  end
  assign perf_issue_o = perf_issue_q;
  assign perf_block_o = perf_block_q;
`else
  assign perf_issue_o = '0;
  assign perf_block_o = '0;
`endif
`ifndef SYNTHESIS
  a_funct3_legal: assert property (@(posedge clk) disable iff (!rst_n) !(req_valid_i && req_funct3_i[2]))
    else $error("unsupported funct3 %b presented", req_funct3_i);
  a_tag_upper_zero: assert property (@(posedge clk) disable iff (!rst_n) !resp_valid_o || ((pop_ent.rd >> RD_W) == '0))
    else $error("response tag upper bits nonzero");
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed scoreboard bench for mul_issue_ctrl with a fixed-latency multiplier model.
module tb_mul_issue_ctrl;
  localparam int LAT  = 3;
  localparam int RD_W = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [2:0] req_funct3_i = '0;
  logic [RD_W-1:0] req_rd_i = '0;
  logic flush_i = 1'b0;
  logic mul_start_o;
  logic [1:0] mul_sign_o;
  logic mul_higher_o;
  logic [31:0] res_data_i;
  logic resp_valid_o;
  logic resp_ready_i = 1'b0;
  logic [RD_W-1:0] resp_rd_o;
  logic [31:0] resp_data_o;
  logic [31:0] perf_issue_o, perf_block_o;
  logic [31:0] cur_data = '0;
  logic [31:0] pipe [LAT];
  logic [RD_W+31:0] exp_q [$];
  int checks = 0;
  int errs = 0;
  int exp_iss = 0;
  int exp_blk = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.LAT(LAT), .RD_W(RD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_funct3_i(req_funct3_i),
    .req_rd_i    (req_rd_i),
    .flush_i     (flush_i),
    .mul_start_o (mul_start_o),
    .mul_sign_o  (mul_sign_o),
    .mul_higher_o(mul_higher_o),
    .res_data_i  (res_data_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rd_o   (resp_rd_o),
    .resp_data_o (resp_data_o),
    .perf_issue_o(perf_issue_o),
    .perf_block_o(perf_block_o)
  );

  // multiplier model: the operand chosen at start emerges LAT cycles later
  always @(posedge clk) begin
    pipe[0] <= mul_start_o ? cur_data : 32'hdead_beef;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign res_data_i = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] dec(input logic [2:0] f3);
    case (f3)
      3'b001:  dec = 3'b111;
      3'b010:  dec = 3'b101;
      3'b011:  dec = 3'b001;
      default: dec = 3'b000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid_o && resp_ready_i && !flush_i) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid_o), 64'd0);
      else begin
        logic [RD_W+31:0] e;
        e = exp_q.pop_front();
        chk("resp_rd", 64'(resp_rd_o), 64'(e[RD_W+31:32]));
        chk("resp_data", 64'(resp_data_o), 64'(e[31:0]));
      end
    end
  end

  task automatic step(input bit v, input logic [2:0] f3, input logic [RD_W-1:0] rd, input logic [31:0] d,
                      input bit fl, input bit rr, input bit er, input bit ev);
    logic [2:0] e;
    @(posedge clk);
    #1;
    req_valid_i  = v;
    req_funct3_i = f3;
    req_rd_i     = rd;
    cur_data     = d;
    flush_i      = fl;
    resp_ready_i = rr;
    #2;
    e = (v && er) ? dec(f3) : 3'b000;
    chk("req_ready", 64'(req_ready_o), 64'(er));
    chk("mul_start", 64'(mul_start_o), 64'(v && er));
    chk("mul_sign", 64'(mul_sign_o), 64'(e[2:1]));
    chk("mul_higher", 64'(mul_higher_o), 64'(e[0]));
    chk("resp_valid", 64'(resp_valid_o), 64'(ev));
`ifdef MUL_PERF_EN
    chk("perf_issue", 64'(perf_issue_o), 64'(exp_iss));
    chk("perf_block", 64'(perf_block_o), 64'(exp_blk));
`else
    chk("perf_issue", 64'(perf_issue_o), 64'd0);
    chk("perf_block", 64'(perf_block_o), 64'd0);
`endif
    if (fl) exp_q.delete();
    if (v && er) begin
      exp_q.push_back({rd, d});
      exp_iss++;
    end
    if (v && !er) exp_blk++;
  endtask

  task automatic idle(input bit rr, input bit er, input bit ev);
    step(1'b0, 3'b000, '0, '0, 1'b0, rr, er, ev);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 64'(mul_start_o), 64'd0);
    chk({tag, "_sign"}, 64'(mul_sign_o), 64'd0);
    chk({tag, "_higher"}, 64'(mul_higher_o), 64'd0);
    chk({tag, "_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_rd"}, 64'(resp_rd_o), 64'd0);
    chk({tag, "_data"}, 64'(resp_data_o), 64'd0);
    chk({tag, "_perf_issue"}, 64'(perf_issue_o), 64'd0);
    chk({tag, "_perf_block"}, 64'(perf_block_o), 64'd0);
  endtask

  initial begin
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    req_rd_i     = 5'd3;
    #12;
    chk_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst_n       = 1'b1;
    idle(1'b0, 1'b1, 1'b0);
    // single MULHSU: response visible in the cycle its result arrives
    step(1'b1, 3'b010, 5'd7, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    chk("mulhsu_rd", 64'(resp_rd_o), 64'd7);
    chk("mulhsu_data", 64'(resp_data_o), 64'h1234_5678);
    idle(1'b1, 1'b1, 1'b0);
    // back-to-back MUL, MULH, MULHU
    step(1'b1, 3'b000, 5'd1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b001, 5'd2, 32'h0000_0022, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b011, 5'd3, 32'h0000_0033, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    chk("b2b_cnt", 64'(dut.cnt_q), 64'd0);
    // backpressure: four credits, then blocked
    for (int k = 0; k < 8; k++)
      step(1'b1, 3'(k % 4), 5'(16 + k), 32'ha000_0000 + 32'(k), 1'b0, 1'b0, k < 4, k >= 3);
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    chk("drain_cnt", 64'(dut.cnt_q), 64'd0);
    // flush after two issues kills both
    step(1'b1, 3'b000, 5'd4, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b001, 5'd5, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b010, 5'd6, 32'h6666_6666, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("flush_cnt", 64'(dut.cnt_q), 64'd0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    step(1'b1, 3'b011, 5'd9, 32'hcafe_f00d, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    chk("post_flush_rd", 64'(resp_rd_o), 64'd9);
    idle(1'b1, 1'b1, 1'b0);
    // reset with one response buffered and two ops in flight
    step(1'b1, 3'b000, 5'd10, 32'haaaa_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    step(1'b1, 3'b001, 5'd11, 32'haaaa_0002, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 3'b010, 5'd12, 32'haaaa_0003, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    rst_n        = 1'b0;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    exp_iss = 0;
    exp_blk = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    req_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) idle(1'b1, 1'b1, 1'b0);
    chk("final_cnt", 64'(dut.cnt_q), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
